dllp_ack_nak_tx: RTL and testbench
==================================

Name: dllp_ack_nak_tx

Overview:
- Transmit-side Ack/Nak DLLP generator for the PCIe data link layer.
- Consumes per-TLP sequence status from the DLLP receive path: seq_num, valid, and Ack/Nak.
- Decides when to send an Ack or Nak, and emits 6-byte Ack/Nak DLLPs with CRC-16 as a 2-beat AXIS stream.
- Output feeds one slave port of the DLLP-to-PHY arbiter mux.

Parameters:
- DATA_WIDTH, 32, AXIS data width; only 32 is supported (elaboration error otherwise).
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 3, tuser width; driven to zero.
- ACK_COALESCE_COUNT, 4, number of Ack-status TLPs that forces an immediate Ack; range 1..255.
- ACK_LATENCY_LIMIT, 255, cycles from the first pending Ack until an Ack is forced; range 1..4095.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-low (asserted when 0).
- link_active_i  in  1  DL_Active; when low, all pending state is flushed.
- seq_num_i  in  12  sequence number of the TLP just checked.
- seq_num_vld_i  in  1  one-cycle strobe qualifying seq_num_i and seq_num_acknack_i.
- seq_num_acknack_i  in  1  1 = TLP good (Ack), 0 = TLP bad (Nak).
- m_axis_dllp_tdata_o  out  DATA_WIDTH  DLLP bytes; byte n on tdata[8n+7:8n].
- m_axis_dllp_tkeep_o  out  KEEP_WIDTH  byte enables.
- m_axis_dllp_tvalid_o  out  1  AXIS valid.
- m_axis_dllp_tlast_o  out  1  last beat of DLLP.
- m_axis_dllp_tuser_o  out  USER_WIDTH  always 0.
- m_axis_dllp_tready_i  in  1  AXIS ready.
- nak_scheduled_o  out  1  NAK_SCHEDULED flag.
- ack_sent_o  out  1  1-cycle pulse on acceptance of an Ack DLLP's last beat.
- nak_sent_o  out  1  1-cycle pulse on acceptance of a Nak DLLP's last beat.

Behaviour:
- Reset (rst_i=0, async):
  - FSM goes to IDLE.
  - All outputs are 0: tvalid, tlast, tdata, tkeep, pulses, nak_scheduled_o.
  - ack_pending=0, coalesce count=0, latency timer=0, last_ack_seq=12'hFFF.
- Status capture, every cycle seq_num_vld_i=1 with link_active_i=1:
  - Ack: last_ack_seq <= seq_num_i; ack_pending <= 1; count += 1, saturating at 255; nak_scheduled cleared.
  - Nak, with nak_scheduled=0: nak_pending <= 1; nak_seq <= seq_num_i - 1 (mod 4096); nak_scheduled <= 1.
  - Nak, with nak_scheduled=1: ignored.
- Latency timer:
  - Runs while ack_pending=1; saturates at ACK_LATENCY_LIMIT.
  - Clears when an Ack frame is launched.
- Launch conditions:
  - Ack fire = ack_pending && (count >= ACK_COALESCE_COUNT || timer == ACK_LATENCY_LIMIT).
  - Nak fire = nak_pending.
  - Nak has priority over Ack.
- FSM IDLE -> BEAT0, on Nak fire or Ack fire:
  - Latch type (Ack 8'h00, Nak 8'h10) and seq (Nak: nak_seq; Ack: last_ack_seq).
  - Clear the launched pending flag. If it is an Ack, also zero count and timer.
  - A status strobe in the same cycle wins: pending re-sets, count becomes 1.
- FSM BEAT0:
  - tvalid=1, tkeep=4'hF, tlast=0.
  - Byte0=type, byte1=0, byte2={4'h0, seq[11:8]}, byte3=seq[7:0].
  - Holds stable until tready, then -> BEAT1.
- FSM BEAT1:
  - tvalid=1, tkeep=4'h3, tlast=1.
  - Byte0=CRC[15:8], byte1=CRC[7:0], bytes 2-3 = 0.
  - On tready: pulse ack_sent_o or nak_sent_o, -> IDLE.
- Timing:
  - Latency from fire condition true to tvalid is 1 cycle.
  - Back-to-back frames are allowed: IDLE is spent for 1 cycle minimum between frames.
- CRC-16:
  - Polynomial 0x100B, seed 0xFFFF, over bytes 0-3.
  - Each byte is processed bit 0 first; the result is inverted and bit-reversed per PCIe DLLP CRC rules.
  - Computed combinationally from the latched fields in IDLE->BEAT0 and registered, so it is stable throughout BEAT1.
- Payload latching: status strobes arriving mid-frame update the pending registers only; the in-flight frame payload never changes.
- link_active_i=0:
  - Clear ack_pending, nak_pending, nak_scheduled, count and timer; ignore strobes.
  - A frame already in BEAT0/BEAT1 completes normally (no AXIS violation).
- Async reset mid-frame drops tvalid immediately; this is permitted.
- Sequence arithmetic is 12-bit modulo: Nak with seq_num_i=0 gives nak_seq=12'hFFF.

Test Plan:
- Coalesce: ACK_COALESCE_COUNT=4; Acks for seq 0,1,2,3 on consecutive cycles, tready=1 -> one DLLP with byte0=00, byte2=00, byte3=03, CRC matches model; ack_sent_o pulses once.
- Latency: one Ack for seq 12'h123, ACK_LATENCY_LIMIT=16 -> tvalid rises 17-18 cycles later; bytes 00,00,01,23; then the CRC beat with tkeep=3, tlast=1.
- Nak priority/once: Ack seq 5 then Nak (seq_num_i=6) same-cycle-later -> Nak DLLP byte0=10, seq=005; a second Nak is ignored (no DLLP); Ack seq 6 clears nak_scheduled_o.
- Backpressure: hold tready=0 for 10 cycles in BEAT0 while new Acks arrive -> tdata/tkeep/tlast stable; the next Ack DLLP carries the newest seq.
- Wrap: Nak with seq_num_i=0 -> Nak DLLP seq=FFF, bytes 10,00,0F,FF.
- Link down/reset: link_active_i=0 with ack_pending -> no DLLP emitted; rst_i=0 during BEAT1 -> tvalid=0 asynchronously, and after release no frame is emitted until new status arrives.

Source files
------------

// File: rtl/dllp_ack_nak_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : dllp_ack_nak_tx_if
// Description : AXI-Stream bundle carrying Ack/Nak DLLP beats toward the
//               DLLP-to-PHY arbiter.
//               master : tdata, tkeep, tvalid, tlast, tuser out; tready in
//               slave  : tdata, tkeep, tvalid, tlast, tuser in;  tready out
// Revision    : 1.0 - initial release
// ============================================================================
interface dllp_ack_nak_tx_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 3
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tready;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/dllp_ack_nak_tx.sv
`default_nettype none
// ============================================================================
// Module      : dllp_ack_nak_tx
// Description : Transmit-side PCIe Ack/Nak DLLP generator. Collects per-TLP
//               sequence status, coalesces Acks (count or latency), schedules
//               at most one Nak, and emits 6-byte DLLPs (type, seq, CRC-16)
//               as a 2-beat AXI-Stream frame.
// Ports       : clk_i, rst_i (async, active-low)
//               link_active_i              DL_Active; low flushes pending state
//               seq_num_i/_vld_i/_acknack_i  status strobe from receive path
//               m_axis_dllp                AXIS master (interface)
//               nak_scheduled_o            NAK_SCHEDULED flag
//               ack_sent_o / nak_sent_o    pulse on last-beat acceptance
// Revision    : 1.0 - initial release
// ============================================================================
module dllp_ack_nak_tx #(
  parameter int DATA_WIDTH         = 32,
  parameter int KEEP_WIDTH         = DATA_WIDTH / 8,
  parameter int USER_WIDTH         = 3,
  parameter int ACK_COALESCE_COUNT = 4,
  parameter int ACK_LATENCY_LIMIT  = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              link_active_i,
  input  logic [11:0]       seq_num_i,
  input  logic              seq_num_vld_i,
  input  logic              seq_num_acknack_i,
  dllp_ack_nak_tx_if.master m_axis_dllp,
  output logic              nak_scheduled_o,
  output logic              ack_sent_o,
  output logic              nak_sent_o
);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("dllp_ack_nak_tx: only DATA_WIDTH = 32 is supported");
  end
  if (ACK_COALESCE_COUNT < 1 || ACK_COALESCE_COUNT > 255) begin : g_bad_coalesce
    $error("dllp_ack_nak_tx: ACK_COALESCE_COUNT must be 1..255");
  end
  if (ACK_LATENCY_LIMIT < 1 || ACK_LATENCY_LIMIT > 4095) begin : g_bad_latency
    $error("dllp_ack_nak_tx: ACK_LATENCY_LIMIT must be 1..4095");
  end

  localparam logic [1:0]  ST_IDLE         = 2'd0;
  localparam logic [1:0]  ST_BEAT0        = 2'd1;
  localparam logic [1:0]  ST_BEAT1        = 2'd2;
  localparam logic [7:0]  TYPE_ACK        = 8'h00;
  localparam logic [7:0]  TYPE_NAK        = 8'h10;
  localparam logic [7:0]  COALESCE_THRESH = 8'(ACK_COALESCE_COUNT);
  localparam logic [11:0] LATENCY_LIMIT   = 12'(ACK_LATENCY_LIMIT);

  // CRC-16 (poly 0x100B, seed 0xFFFF) over the 4 header bytes, byte 0 first,
  // each byte LSB first. The remainder is complemented and bit-reversed.
  function automatic logic [15:0] dllp_crc(input logic [31:0] word);
    logic [15:0] c;
    logic        fb;
    logic [15:0] res;
    c = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      fb = c[15] ^ word[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
    end
    for (int i = 0; i < 16; i++) begin
      res[i] = ~c[15-i];
    end
    return res;
  endfunction

  logic [1:0]  state;
  logic        ack_pending;
  logic        nak_pending;
  logic        nak_scheduled;
  logic [7:0]  ack_count;
  logic [11:0] ack_timer;
  logic [11:0] last_ack_seq;
  logic [11:0] nak_seq;
  logic [31:0] frame_word;
  logic [15:0] frame_crc;
  logic        frame_is_nak;

  logic        launch_ok;
  logic        ack_fire;
  logic        launch_nak;
  logic        launch_ack;
  logic [7:0]  launch_type;
  logic [11:0] launch_seq;
  logic [31:0] launch_word;
  logic [7:0]  ack_count_inc;
  logic        beat1_accept;

  // Frames only start from IDLE, so one IDLE cycle always separates frames.
  assign launch_ok     = (state == ST_IDLE) && link_active_i;
  assign ack_fire      = ack_pending &&
                         ((ack_count >= COALESCE_THRESH) || (ack_timer == LATENCY_LIMIT));
  assign launch_nak    = launch_ok && nak_pending;
  assign launch_ack    = launch_ok && !nak_pending && ack_fire;
  assign launch_type   = launch_nak ? TYPE_NAK : TYPE_ACK;
  assign launch_seq    = launch_nak ? nak_seq : last_ack_seq;
  assign launch_word   = {launch_seq[7:0], 4'h0, launch_seq[11:8], 8'h00, launch_type};
  assign ack_count_inc = (ack_count == 8'hFF) ? 8'hFF : ack_count + 8'd1;
  assign beat1_accept  = (state == ST_BEAT1) && m_axis_dllp.tready;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= ST_IDLE;
      ack_pending   <= 1'b0;
      nak_pending   <= 1'b0;
      nak_scheduled <= 1'b0;
      ack_count     <= 8'd0;
      ack_timer     <= 12'd0;
      last_ack_seq  <= 12'hFFF;
      nak_seq       <= 12'd0;
      frame_word    <= 32'd0;
      frame_crc     <= 16'd0;
      frame_is_nak  <= 1'b0;
    end else begin
      // Frame sequencing; the payload is frozen at launch so later status
      // strobes only touch the pending registers.
      case (state)
        ST_IDLE: begin
          if (launch_nak || launch_ack) begin
            state        <= ST_BEAT0;
            frame_word   <= launch_word;
            frame_crc    <= dllp_crc(launch_word);
            frame_is_nak <= launch_nak;
          end
        end
        ST_BEAT0: if (m_axis_dllp.tready) state <= ST_BEAT1;
        ST_BEAT1: if (m_axis_dllp.tready) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase

      if (!link_active_i) begin
        ack_pending   <= 1'b0;
        nak_pending   <= 1'b0;
        nak_scheduled <= 1'b0;
        ack_count     <= 8'd0;
        ack_timer     <= 12'd0;
      end else begin
        if (launch_nak) nak_pending <= 1'b0;

        if (launch_ack) begin
          ack_pending <= 1'b0;
          ack_count   <= 8'd0;
          ack_timer   <= 12'd0;
        end else if (ack_pending && ack_timer != LATENCY_LIMIT) begin
          ack_timer <= ack_timer + 12'd1;
        end

        // A strobe in the launch cycle overrides the launch-time clears.
        if (seq_num_vld_i) begin
          if (seq_num_acknack_i) begin
            last_ack_seq  <= seq_num_i;
            ack_pending   <= 1'b1;
            nak_scheduled <= 1'b0;
            ack_count     <= launch_ack ? 8'd1 : ack_count_inc;
          end else if (!nak_scheduled) begin
            nak_pending   <= 1'b1;
            nak_seq       <= seq_num_i - 12'd1;
            nak_scheduled <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    m_axis_dllp.tvalid = 1'b0;
    m_axis_dllp.tdata  = '0;
    m_axis_dllp.tkeep  = '0;
    m_axis_dllp.tlast  = 1'b0;
    m_axis_dllp.tuser  = USER_WIDTH'(0);
    case (state)
      ST_BEAT0: begin
        m_axis_dllp.tvalid = 1'b1;
        m_axis_dllp.tdata  = DATA_WIDTH'(frame_word);
        m_axis_dllp.tkeep  = KEEP_WIDTH'(4'hF);
      end
      ST_BEAT1: begin
        m_axis_dllp.tvalid = 1'b1;
        m_axis_dllp.tdata  = DATA_WIDTH'({16'h0000, frame_crc[7:0], frame_crc[15:8]});
        m_axis_dllp.tkeep  = KEEP_WIDTH'(4'h3);
        m_axis_dllp.tlast  = 1'b1;
      end
      default: ;
    endcase
  end

  assign nak_scheduled_o = nak_scheduled;
  assign ack_sent_o      = beat1_accept && !frame_is_nak;
  assign nak_sent_o      = beat1_accept && frame_is_nak;

endmodule
`default_nettype wire

// File: tb/tb_dllp_ack_nak_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_dllp_ack_nak_tx
// Description : Self-checking bench for dllp_ack_nak_tx. A reference model
//               holds the expected outgoing beats in a queue and predicts
//               every output each cycle; directed scenarios add fixed-value
//               checks on frame contents and counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dllp_ack_nak_tx;

  localparam int COAL = 4;
  localparam int LIM  = 16;

  logic        clk;
  logic        rst_n;
  logic        link_active;
  logic [11:0] seq_num;
  logic        seq_vld;
  logic        seq_acknack;
  logic        nak_scheduled;
  logic        ack_sent;
  logic        nak_sent;

  dllp_ack_nak_tx_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(3)) axis_if ();

  dllp_ack_nak_tx #(
    .DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(3),
    .ACK_COALESCE_COUNT(COAL), .ACK_LATENCY_LIMIT(LIM)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .link_active_i(link_active),
    .seq_num_i(seq_num), .seq_num_vld_i(seq_vld), .seq_num_acknack_i(seq_acknack),
    .m_axis_dllp(axis_if),
    .nak_scheduled_o(nak_scheduled), .ack_sent_o(ack_sent), .nak_sent_o(nak_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        nak;
  } beat_t;

  beat_t       exp_q[$];
  bit          m_ack_pend, m_nak_pend, m_nak_sched;
  int          m_cnt, m_tmr;
  int unsigned m_last_ack, m_nak_seq;

  function automatic logic [15:0] model_crc(input int unsigned word);
    int unsigned r, msb, inb, res;
    r = 32'hFFFF;
    for (int k = 0; k < 32; k++) begin
      msb = (r >> 15) & 1;
      inb = (word >> k) & 1;
      r   = (r << 1) & 32'hFFFF;
      if ((msb ^ inb) != 0) r = r ^ 32'h100B;
    end
    r   = ~r & 32'hFFFF;
    res = 0;
    for (int k = 0; k < 16; k++) begin
      if (((r >> k) & 1) != 0) res = res | (1 << (15 - k));
    end
    return 16'(res);
  endfunction

  task automatic model_reset();
    m_ack_pend  = 0;
    m_nak_pend  = 0;
    m_nak_sched = 0;
    m_cnt       = 0;
    m_tmr       = 0;
    m_last_ack  = 4095;
    m_nak_seq   = 0;
    exp_q.delete();
  endtask

  task automatic push_frame(input int unsigned ftype, input int unsigned seq, input bit is_nak);
    int unsigned w0, crc;
    beat_t b;
    w0  = ftype + (seq / 256) * 65536 + (seq % 256) * 16777216;
    crc = model_crc(w0);
    b.data = w0; b.keep = 4'hF; b.last = 1'b0; b.nak = is_nak;
    exp_q.push_back(b);
    b.data = (crc >> 8) + (crc & 255) * 256; b.keep = 4'h3; b.last = 1'b1;
    exp_q.push_back(b);
  endtask

  // Advances the model across the coming clock edge given this cycle's inputs.
  task automatic model_advance(input bit vld, input bit an, input int unsigned seq,
                               input bit link, input bit ready);
    bit was_idle, fire_nak, fire_ack, ack_was_pending;
    if (!rst_n) begin
      model_reset();
      return;
    end
    was_idle        = (exp_q.size() == 0);
    ack_was_pending = m_ack_pend;
    if (!was_idle && ready) exp_q.delete(0);
    if (!link) begin
      m_ack_pend = 0; m_nak_pend = 0; m_nak_sched = 0; m_cnt = 0; m_tmr = 0;
      return;
    end
    fire_nak = was_idle && m_nak_pend;
    fire_ack = was_idle && !fire_nak && m_ack_pend && (m_cnt >= COAL || m_tmr == LIM);
    if (fire_nak) begin
      push_frame(32'h10, m_nak_seq, 1'b1);
      m_nak_pend = 0;
    end
    if (fire_ack) begin
      push_frame(32'h00, m_last_ack, 1'b0);
      m_ack_pend = 0; m_cnt = 0; m_tmr = 0;
    end else if (ack_was_pending && m_tmr < LIM) begin
      m_tmr++;
    end
    if (vld) begin
      if (an) begin
        m_last_ack  = seq % 4096;
        m_ack_pend  = 1;
        m_nak_sched = 0;
        if (m_cnt < 255) m_cnt++;
      end else if (!m_nak_sched) begin
        m_nak_pend  = 1;
        m_nak_sched = 1;
        m_nak_seq   = (seq + 4095) % 4096;
      end
    end
  endtask

  // ---------------- observation bookkeeping ----------------
  int          frames_seen, acks_seen, naks_seen;
  logic [31:0] beat0_seen[$];
  logic        obs_tvalid, obs_nak_sched;

  task automatic clear_obs();
    frames_seen = 0; acks_seen = 0; naks_seen = 0;
    beat0_seen.delete();
  endtask

  function automatic logic [31:0] beat0_at(input int idx);
    if (idx < beat0_seen.size()) return beat0_seen[idx];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic cycle(input bit vld, input bit an, input int unsigned seq,
                       input bit link, input bit ready);
    beat_t head;
    bit    busy;
    @(negedge clk);
    seq_vld        = vld;
    seq_acknack    = an;
    seq_num        = 12'(seq);
    link_active    = link;
    axis_if.tready = ready;
    #1;
    busy = (exp_q.size() > 0);
    head = busy ? exp_q[0] : '0;
    check("tvalid",    32'(axis_if.tvalid), 32'(busy));
    check("tdata",     axis_if.tdata,       head.data);
    check("tkeep",     32'(axis_if.tkeep),  32'(head.keep));
    check("tlast",     32'(axis_if.tlast),  32'(head.last));
    check("tuser",     32'(axis_if.tuser),  32'd0);
    check("nak_sched", 32'(nak_scheduled),  32'(m_nak_sched));
    check("ack_sent",  32'(ack_sent),       32'(busy && head.last && ready && !head.nak));
    check("nak_sent",  32'(nak_sent),       32'(busy && head.last && ready && head.nak));
    if (axis_if.tvalid && ready) begin
      if (axis_if.tlast) frames_seen++;
      else beat0_seen.push_back(axis_if.tdata);
    end
    acks_seen    += int'(ack_sent);
    naks_seen    += int'(nak_sent);
    obs_tvalid    = axis_if.tvalid;
    obs_nak_sched = nak_scheduled;
    model_advance(vld, an, seq, link, ready);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 1, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int linkdown_left;
    rst_n          = 1'b0;
    link_active    = 1'b1;
    seq_vld        = 1'b0;
    seq_acknack    = 1'b0;
    seq_num        = 12'd0;
    axis_if.tready = 1'b1;
    obs_tvalid     = 1'b0;
    obs_nak_sched  = 1'b0;
    model_reset();
    clear_obs();
    repeat (2) @(posedge clk);
    repeat (3) cycle(0, 0, 0, 1, 1);
    rst_n = 1'b1;
    idle(3);

    // Coalesce: four Acks on consecutive cycles force one Ack DLLP.
    clear_obs();
    for (int i = 0; i < 4; i++) cycle(1, 1, i, 1, 1);
    idle(12);
    check("coal_frames", frames_seen, 1);
    check("coal_ack_pulses", acks_seen, 1);
    check("coal_beat0", beat0_at(0), 32'h0300_0000);

    // Latency: a lone Ack is forced out by the timer.
    clear_obs();
    cycle(1, 1, 32'h123, 1, 1);
    lat = 0;
    for (int i = 0; i < 40 && !obs_tvalid; i++) begin
      cycle(0, 0, 0, 1, 1);
      lat++;
    end
    check("lat_window", 32'(lat >= 17 && lat <= 18), 32'd1);
    idle(5);
    check("lat_frames", frames_seen, 1);
    check("lat_beat0", beat0_at(0), 32'h2301_0000);

    // Nak priority, single Nak while scheduled, Ack clears the flag.
    clear_obs();
    cycle(1, 1, 5, 1, 1);
    cycle(1, 0, 6, 1, 1);
    idle(4);
    check("nak_beat0", beat0_at(0), 32'h0500_0010);
    cycle(1, 0, 9, 1, 1);
    cycle(0, 0, 0, 1, 1);
    check("nak_sched_held", 32'(obs_nak_sched), 32'd1);
    idle(25);
    check("nak_once", naks_seen, 1);
    check("nak_then_ack", acks_seen, 1);
    cycle(1, 1, 6, 1, 1);
    cycle(0, 0, 0, 1, 1);
    check("nak_sched_cleared", 32'(obs_nak_sched), 32'd0);
    idle(25);

    // Backpressure: stall BEAT0 while newer Acks arrive.
    clear_obs();
    for (int i = 0; i < 4; i++) cycle(1, 1, 10 + i, 1, 0);
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) cycle(i < 3, 1, 20 + i, 1, 0);
    idle(30);
    check("bp_frames", frames_seen, 2);
    check("bp_first_beat0", beat0_at(0), 32'h0D00_0000);
    check("bp_newest_beat0", beat0_at(1), 32'h1600_0000);

    // Wrap: Nak for sequence 0 reports 0xFFF.
    clear_obs();
    cycle(1, 0, 0, 1, 1);
    idle(6);
    check("wrap_beat0", beat0_at(0), 32'hFF0F_0010);
    check("wrap_naks", naks_seen, 1);

    // Link down flushes a pending Ack.
    clear_obs();
    cycle(1, 1, 7, 1, 1);
    idle(3);
    repeat (4) cycle(0, 0, 0, 0, 1);
    idle(40);
    check("linkdown_frames", frames_seen, 0);

    // Async reset while a frame sits in BEAT1.
    for (int i = 0; i < 4; i++) cycle(1, 1, 30 + i, 1, 0);
    for (int i = 0; i < 10 && !obs_tvalid; i++) cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_tvalid", 32'(axis_if.tvalid), 32'd0);
    check("async_rst_tdata", axis_if.tdata, 32'd0);
    model_reset();
    repeat (2) cycle(0, 0, 0, 1, 1);
    rst_n = 1'b1;
    clear_obs();
    idle(40);
    check("post_reset_frames", frames_seen, 0);

    // Randomized traffic with occasional link drops and backpressure.
    linkdown_left = 0;
    for (int i = 0; i < 3000; i++) begin
      bit vld, an, ready;
      vld   = ($urandom_range(0, 99) < 35);
      an    = ($urandom_range(0, 9) != 0);
      ready = ($urandom_range(0, 3) != 0);
      if (linkdown_left > 0) linkdown_left--;
      else if ($urandom_range(0, 299) == 0) linkdown_left = int'($urandom_range(1, 6));
      cycle(vld, an, $urandom_range(0, 4095), linkdown_left == 0, ready);
    end
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
